// File: rtl/ahmes_mem_arbiter_pkg.sv
// Shared types and default widths for the Ahmes memory arbiter and its requesters.
package ahmes_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ahmes_mem_arbiter_if.sv
// Requester-side req/ack bus with pipelined read return; one instance per arbiter port.
interface ahmes_mem_arbiter_if #(
  parameter int unsigned ADDR_W = ahmes_pkg::ADDR_W,
  parameter int unsigned DATA_W = ahmes_pkg::DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, rvalid
  );

endinterface

// File: rtl/ahmes_rd_return.sv
// Two-stage read tag pipeline that steers RAM read data back to the port that issued the read.
module ahmes_rd_return #(
  parameter int unsigned DATA_W = ahmes_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_rd,
  input  ahmes_pkg::owner_t   issue_owner,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                cpu_rvalid,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                dbg_rvalid,
  output logic [DATA_W-1:0]   dbg_rdata
);
  import ahmes_pkg::*;

  logic   s1_vld_q, s2_vld_q;
  owner_t s1_own_q, s2_own_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_own_q <= OWN_CPU;
      s2_vld_q <= 1'b0;
      s2_own_q <= OWN_CPU;
    end else begin
      s1_vld_q <= issue_rd;
      s1_own_q <= issue_owner;
      s2_vld_q <= s1_vld_q;
      s2_own_q <= s1_own_q;
    end
  end

  // Data lines are zeroed when not valid so idle ports never show stale RAM output.
  always_comb begin
    cpu_rvalid = s2_vld_q && (s2_own_q == OWN_CPU);
    dbg_rvalid = s2_vld_q && (s2_own_q == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

endmodule

// File: rtl/ahmes_mem_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU and the debug/loader port,
// with starvation protection for debug and a debug bus-lock that stalls the CPU.
module ahmes_mem_arbiter #(
  parameter int unsigned ADDR_W   = ahmes_pkg::ADDR_W,
  parameter int unsigned DATA_W   = ahmes_pkg::DATA_W,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  ahmes_mem_arbiter_if.slave  cpu,
  ahmes_mem_arbiter_if.slave  dbg,
  input  logic                dbg_lock,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                cpu_stall,
  output logic                owner
);
  import ahmes_pkg::*;

  localparam int unsigned     CntW    = 4;
  localparam logic [CntW-1:0] MaxWait = CntW'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              cpu_ack, dbg_ack, accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  owner_t            sel_owner;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q, mem_re_q;
  owner_t            owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= OPEN;
    else       state_q <= state_d;
  end

  // Lock is taken by an accepted locking debug access and held while dbg_lock stays high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OPEN:    if (dbg_ack && dbg_lock) state_d = LOCKED;
      LOCKED:  if (!dbg_lock)           state_d = OPEN;
    endcase
  end

  always_comb begin
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    cpu_stall = 1'b0;
    unique case (state_q)
      OPEN: begin
        if (dbg.req && (!cpu.req || wait_q == MaxWait)) dbg_ack = 1'b1;
        else                                            cpu_ack = cpu.req;
      end
      LOCKED: begin
        cpu_stall = 1'b1;
        dbg_ack   = dbg.req;
      end
    endcase
  end

  always_comb begin
    wait_d = '0;
    if (dbg.req && !dbg_ack) wait_d = (wait_q == MaxWait) ? wait_q : wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  assign accept    = cpu_ack | dbg_ack;
  assign sel_we    = dbg_ack ? dbg.we    : cpu.we;
  assign sel_addr  = dbg_ack ? dbg.addr  : cpu.addr;
  assign sel_wdata = dbg_ack ? dbg.wdata : cpu.wdata;
  assign sel_owner = dbg_ack ? OWN_DBG   : OWN_CPU;

  // Address/data/owner hold when idle; only the strobes are cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      owner_q     <= OWN_CPU;
    end else if (accept) begin
      mem_addr_q  <= sel_addr;
      mem_wdata_q <= sel_wdata;
      mem_we_q    <= sel_we;
      mem_re_q    <= ~sel_we;
      owner_q     <= sel_owner;
    end else begin
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign owner     = owner_q;
  assign cpu.ack   = cpu_ack;
  assign dbg.ack   = dbg_ack;

  ahmes_rd_return #(
    .DATA_W (DATA_W)
  ) u_rd_return (
    .clk         (clk),
    .reset       (reset),
    .issue_rd    (accept & ~sel_we),
    .issue_owner (sel_owner),
    .mem_rdata   (mem_rdata),
    .cpu_rvalid  (cpu.rvalid),
    .cpu_rdata   (cpu.rdata),
    .dbg_rvalid  (dbg.rvalid),
    .dbg_rdata   (dbg.rdata)
  );

endmodule

// File: tb/tb_ahmes_mem_arbiter.sv
// Self-checking bench for ahmes_mem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration and read-return rules.
module tb_ahmes_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dbg_lock = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic          cpu_stall, owner;
  logic [DW-1:0] ram [256];

  int n_checks = 0;
  int n_pass   = 0;

  ahmes_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_bus ();
  ahmes_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_bus ();

  ahmes_mem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_bus),
    .dbg       (dbg_bus),
    .dbg_lock  (dbg_lock),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cpu_stall (cpu_stall),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_bus.req = 1'b0; cpu_bus.we = 1'b0; cpu_bus.addr = '0; cpu_bus.wdata = '0;
    dbg_bus.req = 1'b0; dbg_bus.we = 1'b0; dbg_bus.addr = '0; dbg_bus.wdata = '0;
    dbg_lock = 1'b0;
  endtask

  task automatic test_reset();
    logic [51:0] outs;
    @(negedge clk);
    outs = {cpu_bus.ack, dbg_bus.ack, cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata,
            dbg_bus.rdata, mem_addr, mem_wdata, mem_we, mem_re, cpu_stall, owner};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs);
    else n_pass++;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_we, mem_re, cpu_stall, owner} !== 4'b0)
      $display("FAIL post_reset_idle: got %b want 0000", {mem_we, mem_re, cpu_stall, owner});
    else n_pass++;
  endtask

  task automatic test_cpu_read();
    ram[8'h10] = 8'h5A;
    cyc();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h10;
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.ack, dbg_bus.ack} !== 2'b10)
      $display("FAIL cpu_rd_ack: got %b want 10", {cpu_bus.ack, dbg_bus.ack});
    else n_pass++;
    cyc();
    cpu_bus.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_re, mem_we, owner, mem_addr} !== {3'b100, 8'h10})
      $display("FAIL cpu_rd_mem: got re/we/own/addr %b%b%b %h want 100 10",
               mem_re, mem_we, owner, mem_addr);
    else n_pass++;
    n_checks++;
    if ({cpu_bus.rvalid, dbg_bus.rvalid} !== 2'b00)
      $display("FAIL cpu_rd_early_rvalid: got %b want 00", {cpu_bus.rvalid, dbg_bus.rvalid});
    else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata} !== {2'b10, 8'h5A})
      $display("FAIL cpu_rd_data: got v=%b%b d=%h want v=10 d=5a",
               cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++;
    if (cpu_bus.rvalid !== 1'b0) $display("FAIL cpu_rd_pulse: got %b want 0", cpu_bus.rvalid);
    else n_pass++;
  endtask

  task automatic test_dbg_write_read();
    cyc();
    dbg_bus.req = 1'b1; dbg_bus.we = 1'b1; dbg_bus.addr = 8'h20; dbg_bus.wdata = 8'hC3;
    @(negedge clk);
    n_checks++;
    if (dbg_bus.ack !== 1'b1) $display("FAIL dbg_wr_ack: got %b want 1", dbg_bus.ack);
    else n_pass++;
    cyc();
    dbg_bus.we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dbg_bus.ack, mem_we, mem_re, owner, mem_addr, mem_wdata} !== {4'b1101, 8'h20, 8'hC3})
      $display("FAIL dbg_wr_mem: got ack/we/re/own %b%b%b%b addr %h data %h want 1101 20 c3",
               dbg_bus.ack, mem_we, mem_re, owner, mem_addr, mem_wdata);
    else n_pass++;
    cyc();
    dbg_bus.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_re, mem_we, dbg_bus.rvalid} !== 3'b100)
      $display("FAIL dbg_rd_mem: got re/we/rv %b%b%b want 100", mem_re, mem_we, dbg_bus.rvalid);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++;
    if ({dbg_bus.rvalid, cpu_bus.rvalid, dbg_bus.rdata} !== {2'b10, 8'hC3})
      $display("FAIL dbg_rd_data: got v=%b%b d=%h want v=10 d=c3",
               dbg_bus.rvalid, cpu_bus.rvalid, dbg_bus.rdata);
    else n_pass++;
  endtask

  task automatic test_starvation();
    cyc();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h00;
    dbg_bus.req = 1'b1; dbg_bus.we = 1'b0; dbg_bus.addr = 8'h01;
    for (int c = 0; c < 12; c++) begin
      logic want_dbg;
      want_dbg = (c == 4) || (c == 9);
      @(negedge clk);
      n_checks++;
      if ({cpu_bus.ack, dbg_bus.ack} !== {~want_dbg, want_dbg})
        $display("FAIL starve_c%0d: got cpu/dbg ack %b%b want %b%b", c,
                 cpu_bus.ack, dbg_bus.ack, ~want_dbg, want_dbg);
      else n_pass++;
      cyc();
    end
    idle();
    repeat (3) cyc();
  endtask

  task automatic test_lock();
    int k = 0;
    bit got = 1'b0;
    cyc();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h05;
    dbg_bus.req = 1'b1; dbg_bus.we = 1'b1; dbg_bus.addr = 8'h30; dbg_bus.wdata = 8'hA0;
    dbg_lock = 1'b1;
    while (!got && k < 10) begin
      @(negedge clk);
      if (dbg_bus.ack === 1'b1) got = 1'b1;
      else begin
        cyc();
        k++;
      end
    end
    n_checks++;
    if (!got || k != MW) $display("FAIL lock_win: dbg acked=%0d after %0d cycles want 1 after %0d",
                                  got, k, MW);
    else n_pass++;
    n_checks++;
    if (cpu_stall !== 1'b0) $display("FAIL lock_stall_c0: got %b want 0", cpu_stall);
    else n_pass++;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      dbg_bus.addr = 8'(8'h30 + c);
      dbg_lock = (c != 3);
      @(negedge clk);
      n_checks++;
      if ({cpu_stall, cpu_bus.ack, dbg_bus.ack} !== 3'b101)
        $display("FAIL lock_c%0d: got stall/cpu/dbg %b%b%b want 101", c,
                 cpu_stall, cpu_bus.ack, dbg_bus.ack);
      else n_pass++;
    end
    cyc();
    dbg_bus.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, cpu_bus.ack} !== 2'b01)
      $display("FAIL unlock_c4: got stall/cpu_ack %b%b want 01", cpu_stall, cpu_bus.ack);
    else n_pass++;
    cyc();
    idle();
    repeat (3) cyc();
  endtask

  task automatic test_interleave();
    ram[8'h01] = 8'h11; ram[8'h02] = 8'h22; ram[8'h03] = 8'h33;
    cyc();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h01;
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.ack, dbg_bus.ack} !== 2'b10)
      $display("FAIL ilv_ack0: got %b want 10", {cpu_bus.ack, dbg_bus.ack});
    else n_pass++;
    cyc();
    cpu_bus.req = 1'b0;
    dbg_bus.req = 1'b1; dbg_bus.we = 1'b0; dbg_bus.addr = 8'h02;
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.ack, dbg_bus.ack} !== 2'b01)
      $display("FAIL ilv_ack1: got %b want 01", {cpu_bus.ack, dbg_bus.ack});
    else n_pass++;
    cyc();
    dbg_bus.req = 1'b0;
    cpu_bus.req = 1'b1; cpu_bus.addr = 8'h03;
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.ack, cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata} !== {3'b110, 8'h11})
      $display("FAIL ilv_c2: got ack/cv/dv %b%b%b d=%h want 110 d=11",
               cpu_bus.ack, cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata);
    else n_pass++;
    cyc();
    cpu_bus.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.rvalid, dbg_bus.rvalid, dbg_bus.rdata} !== {2'b01, 8'h22})
      $display("FAIL ilv_c3: got cv/dv %b%b d=%h want 01 d=22",
               cpu_bus.rvalid, dbg_bus.rvalid, dbg_bus.rdata);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_checks++;
    if ({cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata} !== {2'b10, 8'h33})
      $display("FAIL ilv_c4: got cv/dv %b%b d=%h want 10 d=33",
               cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata);
    else n_pass++;
    cyc();
  endtask

  task automatic test_reset_mid();
    logic [51:0] outs;
    cyc();
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h10;
    @(negedge clk);
    n_checks++;
    if (cpu_bus.ack !== 1'b1) $display("FAIL rstmid_ack: got %b want 1", cpu_bus.ack);
    else n_pass++;
    cyc();
    cpu_bus.req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    outs = {cpu_bus.ack, dbg_bus.ack, cpu_bus.rvalid, dbg_bus.rvalid, cpu_bus.rdata,
            dbg_bus.rdata, mem_addr, mem_wdata, mem_we, mem_re, cpu_stall, owner};
    n_checks++;
    if (outs !== '0) $display("FAIL rstmid_outputs: got %h want 0", outs);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      cyc();
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({cpu_bus.rvalid, dbg_bus.rvalid} !== 2'b00)
        $display("FAIL rstmid_rvalid_%0d: got %b want 00", c, {cpu_bus.rvalid, dbg_bus.rvalid});
      else n_pass++;
    end
    // Enter lock, then reset while dbg_lock is still high: the lock must not survive.
    cyc();
    dbg_bus.req = 1'b1; dbg_bus.we = 1'b1; dbg_bus.addr = 8'h40; dbg_lock = 1'b1;
    cyc();
    dbg_bus.req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1) $display("FAIL rstlock_stall: got %b want 1", cpu_stall);
    else n_pass++;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cpu_bus.req = 1'b1; cpu_bus.we = 1'b0; cpu_bus.addr = 8'h00;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, cpu_bus.ack} !== 2'b01)
      $display("FAIL rstlock_open: got stall/cpu_ack %b%b want 01", cpu_stall, cpu_bus.ack);
    else n_pass++;
    cyc();
    idle();
    repeat (3) cyc();
  endtask

  typedef struct {
    int          due;
    bit          own_dbg;
    logic [7:0]  data;
  } rd_exp_t;

  task automatic test_random();
    localparam int N = 400;
    logic [7:0] model_mem [256];
    rd_exp_t    q[$];
    int         m_wait = 0;
    bit         m_locked = 1'b0;
    bit         last_cpu_ack = 1'b1, last_dbg_ack = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = ram[i];
    for (int c = 0; c < N + 3; c++) begin
      bit e_cpu, e_dbg, e_stall, e_cv, e_dv;
      logic [7:0] e_data;
      cyc();
      if (c >= N) begin
        idle();
      end else begin
        if (last_cpu_ack || !cpu_bus.req || $urandom_range(0, 7) == 0) begin
          cpu_bus.req   = ($urandom_range(0, 2) != 0);
          cpu_bus.we    = 1'($urandom);
          cpu_bus.addr  = 8'($urandom_range(0, 15));
          cpu_bus.wdata = 8'($urandom);
        end
        if (last_dbg_ack || !dbg_bus.req || $urandom_range(0, 7) == 0) begin
          dbg_bus.req   = ($urandom_range(0, 2) == 0);
          dbg_bus.we    = 1'($urandom);
          dbg_bus.addr  = 8'($urandom_range(0, 15));
          dbg_bus.wdata = 8'($urandom);
        end
        dbg_lock = m_locked ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      end
      e_cpu = 1'b0; e_dbg = 1'b0;
      e_stall = m_locked;
      if (m_locked) e_dbg = dbg_bus.req;
      else if (dbg_bus.req && (!cpu_bus.req || m_wait >= MW)) e_dbg = 1'b1;
      else e_cpu = cpu_bus.req;
      e_cv = 1'b0; e_dv = 1'b0; e_data = '0;
      if (q.size() > 0 && q[0].due == c) begin
        e_cv = !q[0].own_dbg;
        e_dv = q[0].own_dbg;
        e_data = q[0].data;
        void'(q.pop_front());
      end
      @(negedge clk);
      n_checks++;
      if ({cpu_bus.ack, dbg_bus.ack, cpu_stall} !== {e_cpu, e_dbg, e_stall})
        $display("FAIL rnd_ack_c%0d: got cpu/dbg/stall %b%b%b want %b%b%b", c,
                 cpu_bus.ack, dbg_bus.ack, cpu_stall, e_cpu, e_dbg, e_stall);
      else n_pass++;
      n_checks++;
      if ({cpu_bus.rvalid, dbg_bus.rvalid} !== {e_cv, e_dv})
        $display("FAIL rnd_rvalid_c%0d: got cv/dv %b%b want %b%b", c,
                 cpu_bus.rvalid, dbg_bus.rvalid, e_cv, e_dv);
      else n_pass++;
      if (e_cv || e_dv) begin
        n_checks++;
        if ((e_cv ? cpu_bus.rdata : dbg_bus.rdata) !== e_data)
          $display("FAIL rnd_rdata_c%0d: got %h want %h", c,
                   e_cv ? cpu_bus.rdata : dbg_bus.rdata, e_data);
        else n_pass++;
      end
      if (e_cpu || e_dbg) begin
        bit         w  = e_dbg ? dbg_bus.we : cpu_bus.we;
        logic [7:0] a  = e_dbg ? dbg_bus.addr : cpu_bus.addr;
        logic [7:0] wd = e_dbg ? dbg_bus.wdata : cpu_bus.wdata;
        if (w) model_mem[a] = wd;
        else q.push_back('{due: c + 2, own_dbg: e_dbg, data: model_mem[a]});
      end
      m_wait = (dbg_bus.req && !e_dbg) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      if (m_locked && !dbg_lock) m_locked = 1'b0;
      else if (!m_locked && e_dbg && dbg_lock) m_locked = 1'b1;
      last_cpu_ack = e_cpu;
      last_dbg_ack = e_dbg;
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL rnd_drain: got %0d reads outstanding want 0", q.size());
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    idle();
    test_reset();
    test_cpu_read();
    test_dbg_write_read();
    test_starvation();
    test_lock();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
